// File: rtl/pio_edge_input_if.sv
// Avalon-MM slave bus bundle for the PIO edge-capture input port.
// The master drives address/strobes/data; the slave returns read data and its interrupt.
interface pio_edge_input_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );
endinterface

// File: rtl/pio_edge_input.sv
// Avalon-MM input port: synchronizes board inputs, captures selected edges in a sticky
// write-1-to-clear register and raises a level interrupt for unmasked captures.
module pio_edge_input #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned EDGE_TYPE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   pio_edge_input_if.slave  bus
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_capture;
   logic [1:0]       r_arm;
   logic [31:0]      r_readdata;

   logic             w_write;
   logic             w_armed;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clear;
   logic [WIDTH-1:0] w_capture_d;
   logic [31:0]      w_rdmux;
   logic             w_unused;

   assign w_write  = bus.chipselect & ~bus.write_n;
   assign w_armed  = (r_arm == 2'd3);
   assign w_unused = ^bus.writedata;

   // Edges are ignored until the synchronizer has flushed its reset zeros.
   always_comb begin
      w_edge = '0;
      if (w_armed) begin
         if (EDGE_TYPE == 0) begin
            w_edge = r_sync2 & ~r_prev;
         end else if (EDGE_TYPE == 1) begin
            w_edge = ~r_sync2 & r_prev;
         end else begin
            w_edge = r_sync2 ^ r_prev;
         end
      end
   end

   // A new edge in the clearing cycle must not be lost, so set overrides clear.
   assign w_clear     = (w_write && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
   assign w_capture_d = (r_capture & ~w_clear) | w_edge;

   always_comb begin
      w_rdmux = '0;
      case (bus.address)
         2'd0:    w_rdmux[WIDTH-1:0] = r_sync2;
         2'd2:    w_rdmux[WIDTH-1:0] = r_mask;
         2'd3:    w_rdmux[WIDTH-1:0] = r_capture;
         default: w_rdmux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_prev     <= '0;
         r_arm      <= '0;
         r_mask     <= '0;
         r_capture  <= '0;
         r_readdata <= '0;
      end else begin
         r_sync1    <= in_port;
         r_sync2    <= r_sync1;
         r_prev     <= r_sync2;
         if (!w_armed) begin
            r_arm <= r_arm + 2'd1;
         end
         if (w_write && bus.address == 2'd2) begin
            r_mask <= bus.writedata[WIDTH-1:0];
         end
         r_capture  <= w_capture_d;
         r_readdata <= w_rdmux;
      end
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = |(r_capture & r_mask);

endmodule
